conv_enc_ctrl: RTL and testbench
================================

Name: conv_enc_ctrl

Overview:
- Frame sequencer for the 802.11a rate-1/2 K=7 convolutional encoder.
- Per frame it:
  - clears the encoder shift register;
  - feeds the PSDU bits (SERVICE + data, already scrambled) from an upstream valid/ready source;
  - appends 6 zero tail bits;
  - appends zero pad bits up to a multiple of N_DBPS;
  - punctures the encoder's {B,A} output to rate 1/2, 2/3 or 3/4.
- Sits between the scrambler and the interleaver in the TX chain.

Parameters:
- LEN_W, 16, width of psdu_bits (uncoded data-bit count per frame).
- NDBPS_W, 9, width of ndbps (data bits per OFDM symbol, max 216).

Ports:
- Clk  input  1  clock; all logic on rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle frame start; sampled only in IDLE.
- rate_sel  input  2  0 = 1/2, 1 = 2/3, 2 = 3/4; 3 is treated as 1/2. Latched at start.
- psdu_bits  input  LEN_W  number of data bits to pull from upstream; latched at start.
- ndbps  input  NDBPS_W  bits per symbol; latched at start; must be ≥ 1.
- in_valid  input  1  upstream data bit valid.
- in_bit  input  1  upstream data bit.
- in_ready  output  1  high only in DATA; a transfer occurs when in_valid && in_ready.
- enc_rst_n  output  1  registered, active-low clear to the encoder's reset pin.
- enc_en  output  1  registered; the encoder shifts one bit on the same edge it is sampled.
- enc_din  output  1  bit presented to the encoder (registered with enc_en).
- enc_out  input  2  encoder data_out {B,A}; valid the cycle after enc_en was high.
- out_valid  output  1  punctured output valid.
- out_bits  output  2  punctured bits; bit0 = A, bit1 = B.
- out_mask  output  2  which out_bits are kept: 11, 01 (A only) or 10 (B only).
- busy  output  1  high from the cycle after start until done.
- done  output  1  one-cycle pulse after the last out_valid of the frame.

Behaviour:
- Reset values: state = IDLE, all counters 0, in_ready = 0, enc_en = 0, enc_din = 0, enc_rst_n = 1, out_valid = 0, out_bits = 0, out_mask = 0, busy = 0, done = 0.
- Reset takes effect immediately, including mid-frame; the partially sent frame is abandoned and no done is issued.
- States:
  - IDLE → CLEAR on start.
  - CLEAR (exactly 1 cycle): enc_rst_n = 0, puncture phase reset to 0. Next state is DATA, or TAIL if psdu_bits = 0.
  - DATA: in_ready = 1. Each handshake sets enc_en = 1, enc_din = in_bit and increments data_cnt and sym_cnt. When in_valid = 0 there is no enc_en and no output gap is filled. After the handshake where data_cnt reaches psdu_bits, go to TAIL.
  - TAIL: 6 consecutive cycles with enc_en = 1, enc_din = 0, sym_cnt incrementing. Then go to PAD if sym_cnt ≠ 0, else DRAIN.
  - PAD: enc_en = 1, enc_din = 0 every cycle until sym_cnt wraps to 0, then go to DRAIN.
  - DRAIN (1 cycle): waits for the last encoder output.
  - DONE: done = 1 for 1 cycle, then IDLE.
- sym_cnt counts modulo ndbps: it wraps to 0 when it would equal ndbps. No divider is used.
- Output latency: out_valid is enc_en delayed by 1 cycle, and out_bits = enc_out in that cycle.
- Puncture phase advances on each out_valid:
  - rate 1/2: mask 11 always.
  - rate 2/3: period 2, masks 11, 01.
  - rate 3/4: period 3, masks 11, 01, 10.
  - The phase restarts at 0 in every frame.
- start while busy is ignored. in_valid outside DATA is ignored. Inputs latched at start are stable for the whole frame.
- Total enc_en count = psdu_bits + 6 + pad, and is always a multiple of ndbps.

Optional Feature:
- Macro CONV_ENC_CTRL_STATS_EN.
- Defined:
  - adds output coded_bits (LEN_W+2 bits): the count of kept bits (popcount of out_mask over all out_valid cycles) for the current/last frame.
  - cleared in CLEAR; held after DONE until the next start; reset to 0.
- Undefined: the port and its counter do not exist; all other behaviour is identical.

Decomposition:
- Shared package conv_enc_pkg holds:
  - state encoding constants: IDLE, CLEAR, DATA, TAIL, PAD, DRAIN, DONE;
  - rate codes RATE_1_2 = 0, RATE_2_3 = 1, RATE_3_4 = 2;
  - TAIL_BITS = 6.
- One natural sub-module, conv_puncture: phase counter plus mask lookup, driven by out_valid and the latched rate.

Test Plan:
- Rate 1/2, psdu_bits = 10, ndbps = 24, in_valid always 1 → 1 enc_rst_n low cycle, 10 data + 6 tail + 8 pad = 24 enc_en cycles, 24 out_valid all mask 11 (48 bits), one done pulse.
- Rate 3/4, psdu_bits = 30, ndbps = 36 → 36 enc_en, no PAD state visited; mask sequence 11, 01, 10 repeating; 48 kept bits.
- Rate 2/3, psdu_bits = 100, ndbps = 96 → 192 enc_en (86 pad); masks alternate 11, 01; 288 kept bits. Random in_valid gaps produce identical out_bits content.
- psdu_bits = 0, ndbps = 24, rate 1/2 → CLEAR then TAIL directly; 24 enc_en with enc_din = 0; all out_bits = 00.
- Reset asserted mid-DATA, then a new start → outputs return to reset values immediately, no done; the new frame starts at puncture phase 0 with a clean encoder (known-answer check on all-ones input, first output 11).
- start pulsed while busy, and rate_sel = 3 → the busy start is ignored; rate 3 frame behaves exactly as rate 1/2.

Source files
------------

// File: rtl/conv_enc_pkg.sv
// rtl/conv_enc_pkg.sv - shared states, rate codes and puncture mask lookup for conv_enc_ctrl
package conv_enc_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    DATA,
    TAIL,
    PAD,
    DRAIN,
    DONE
  } state_t;

  localparam logic [1:0] RATE_1_2 = 2'd0;
  localparam logic [1:0] RATE_2_3 = 2'd1;
  localparam logic [1:0] RATE_3_4 = 2'd2;

  localparam int TAIL_BITS = 6;

  // Mask bit0 keeps A, bit1 keeps B; unknown rate codes fall back to 1/2.
  function automatic logic [1:0] punct_mask(input logic [1:0] rate, input logic [1:0] phase);
    logic [1:0] m;
    m = 2'b11;
    case (rate)
      RATE_2_3: m = (phase == 2'd0) ? 2'b11 : 2'b01;
      RATE_3_4: begin
        case (phase)
          2'd0:    m = 2'b11;
          2'd1:    m = 2'b01;
          default: m = 2'b10;
        endcase
      end
      default:  m = 2'b11;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/conv_enc_ctrl_puncture.sv
// rtl/conv_enc_ctrl_puncture.sv - puncture phase counter and keep-mask generator
module conv_puncture
  import conv_enc_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_clr,
  input  logic       i_valid,
  input  logic [1:0] i_rate,
  output logic [1:0] o_mask
);

  logic [1:0] r_phase;
  logic [1:0] w_last;

  always_comb begin
    w_last = 2'd0;
    case (i_rate)
      RATE_2_3: w_last = 2'd1;
      RATE_3_4: w_last = 2'd2;
      default:  w_last = 2'd0;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_phase <= 2'd0;
    end else if (i_clr) begin
      r_phase <= 2'd0;
    end else if (i_valid) begin
      r_phase <= (r_phase == w_last) ? 2'd0 : r_phase + 2'd1;
    end
  end

  assign o_mask = i_valid ? punct_mask(i_rate, r_phase) : 2'b00;

endmodule

// File: rtl/conv_enc_ctrl.sv
// rtl/conv_enc_ctrl.sv - 802.11a K=7 encoder frame sequencer (optional CONV_ENC_CTRL_STATS_EN)
module conv_enc_ctrl
  import conv_enc_pkg::*;
#(
  parameter int LEN_W   = 16,
  parameter int NDBPS_W = 9
) (
  input  logic               i_Clk,
  input  logic               i_reset,
  input  logic               i_start,
  input  logic [1:0]         i_rate_sel,
  input  logic [LEN_W-1:0]   i_psdu_bits,
  input  logic [NDBPS_W-1:0] i_ndbps,
  input  logic               i_in_valid,
  input  logic               i_in_bit,
  output logic               o_in_ready,
  output logic               o_enc_rst_n,
  output logic               o_enc_en,
  output logic               o_enc_din,
  input  logic [1:0]         i_enc_out,
  output logic               o_out_valid,
  output logic [1:0]         o_out_bits,
  output logic [1:0]         o_out_mask,
  output logic               o_busy,
`ifdef CONV_ENC_CTRL_STATS_EN
  output logic [LEN_W+1:0]   o_coded_bits,
`endif
  output logic               o_done
);

  localparam logic [2:0] TAIL_LAST = 3'(TAIL_BITS - 1);

  state_t               r_state;
  state_t               w_next;
  logic [1:0]           r_rate;
  logic [LEN_W-1:0]     r_psdu;
  logic [NDBPS_W-1:0]   r_ndbps;
  logic [LEN_W-1:0]     r_data_cnt;
  logic [NDBPS_W-1:0]   r_sym_cnt;
  logic [2:0]           r_tail_cnt;
  logic                 r_enc_rst_n;
  logic                 r_enc_en;
  logic                 r_enc_din;
  logic                 r_out_valid;
  logic                 r_done;

  logic                 w_start_ok;
  logic                 w_hs;
  logic                 w_en_d;
  logic                 w_din_d;
  logic                 w_sym_inc;
  logic [NDBPS_W-1:0]   w_sym_plus;
  logic [NDBPS_W-1:0]   w_sym_next;
  logic [LEN_W-1:0]     w_data_next;
  logic                 w_clr;
  logic [1:0]           w_mask;

  // The done cycle still counts as busy, so a start coinciding with done is dropped.
  assign w_start_ok  = (r_state == IDLE) && !r_done && i_start;
  assign w_hs        = (r_state == DATA) && i_in_valid;
  assign w_sym_plus  = r_sym_cnt + NDBPS_W'(1);
  assign w_sym_next  = (w_sym_plus == r_ndbps) ? '0 : w_sym_plus;
  assign w_data_next = r_data_cnt + LEN_W'(1);
  assign w_clr       = (r_state == CLEAR);

  always_comb begin
    w_next    = r_state;
    w_en_d    = 1'b0;
    w_din_d   = 1'b0;
    w_sym_inc = 1'b0;
    case (r_state)
      IDLE:  if (w_start_ok) w_next = CLEAR;
      CLEAR: w_next = (r_psdu == '0) ? TAIL : DATA;
      DATA: begin
        if (w_hs) begin
          w_en_d    = 1'b1;
          w_din_d   = i_in_bit;
          w_sym_inc = 1'b1;
          if (w_data_next == r_psdu) w_next = TAIL;
        end
      end
      TAIL: begin
        w_en_d    = 1'b1;
        w_sym_inc = 1'b1;
        if (r_tail_cnt == TAIL_LAST) w_next = (w_sym_next != '0) ? PAD : DRAIN;
      end
      PAD: begin
        w_en_d    = 1'b1;
        w_sym_inc = 1'b1;
        if (w_sym_next == '0) w_next = DRAIN;
      end
      DRAIN:   w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge i_Clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state     <= IDLE;
      r_rate      <= 2'd0;
      r_psdu      <= '0;
      r_ndbps     <= '0;
      r_data_cnt  <= '0;
      r_sym_cnt   <= '0;
      r_tail_cnt  <= 3'd0;
      r_enc_rst_n <= 1'b1;
      r_enc_en    <= 1'b0;
      r_enc_din   <= 1'b0;
      r_out_valid <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_enc_rst_n <= !w_start_ok;
      r_enc_en    <= w_en_d;
      r_enc_din   <= w_din_d;
      r_out_valid <= r_enc_en;
      r_done      <= (r_state == DONE);
      if (w_start_ok) begin
        r_rate  <= i_rate_sel;
        r_psdu  <= i_psdu_bits;
        r_ndbps <= i_ndbps;
      end
      if (w_clr) begin
        r_data_cnt <= '0;
        r_sym_cnt  <= '0;
        r_tail_cnt <= 3'd0;
      end else begin
        if (w_hs) r_data_cnt <= w_data_next;
        if (w_sym_inc) r_sym_cnt <= w_sym_next;
        if (r_state == TAIL) r_tail_cnt <= r_tail_cnt + 3'd1;
      end
    end
  end

  conv_puncture u_punct (
    .i_clk   (i_Clk),
    .i_rst_n (i_reset),
    .i_clr   (w_clr),
    .i_valid (r_out_valid),
    .i_rate  (r_rate),
    .o_mask  (w_mask)
  );

`ifdef CONV_ENC_CTRL_STATS_EN
  logic [LEN_W+1:0] r_coded_bits;

  always_ff @(posedge i_Clk or negedge i_reset) begin
    if (!i_reset) begin
      r_coded_bits <= '0;
    end else if (w_clr) begin
      r_coded_bits <= '0;
    end else if (r_out_valid) begin
      r_coded_bits <= r_coded_bits + (LEN_W+2)'(w_mask[0]) + (LEN_W+2)'(w_mask[1]);
    end
  end

  assign o_coded_bits = r_coded_bits;
`endif

  assign o_in_ready  = (r_state == DATA);
  assign o_enc_rst_n = r_enc_rst_n;
  assign o_enc_en    = r_enc_en;
  assign o_enc_din   = r_enc_din;
  assign o_out_valid = r_out_valid;
  assign o_out_bits  = r_out_valid ? i_enc_out : 2'b00;
  assign o_out_mask  = w_mask;
  assign o_busy      = (r_state != IDLE) || r_done;
  assign o_done      = r_done;

endmodule

// File: tb/tb_conv_enc_ctrl.sv
// tb/tb_conv_enc_ctrl.sv - table-driven bench for conv_enc_ctrl with a K=7 encoder stand-in
module tb_conv_enc_ctrl;

  typedef struct {
    int rate;
    int psdu;
    int ndbps;
    int pat;
    int gap;
    int bstart;
    int exp_en;
    int exp_kept;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  rate_sel = 2'd0;
  logic [15:0] psdu = 16'd0;
  logic [8:0]  ndbps = 9'd1;
  logic        in_valid = 1'b0;
  logic        in_bit = 1'b0;
  logic        in_ready, enc_rst_n, enc_en, enc_din, out_valid, busy, done;
  logic [1:0]  out_bits, out_mask;
  logic [1:0]  enc_out = 2'b00;
  logic [5:0]  enc_sr = 6'd0;
`ifdef CONV_ENC_CTRL_STATS_EN
  logic [17:0] coded_bits;
`endif

  int n_checks = 0;
  int n_err = 0;
  int cur_rate = 0, cur_psdu = 0, cur_pat = 0;
  logic mon_clr = 1'b0;
  int en_cnt, din_ones, ov_cnt, kept, rst_lo, done_cnt, mask_err, bits_err;
  logic [1:0] first_bits;
  logic [5:0] sw_sr;

  always #5 clk = ~clk;

  conv_enc_ctrl dut (
    .i_Clk       (clk),
    .i_reset     (rst_n),
    .i_start     (start),
    .i_rate_sel  (rate_sel),
    .i_psdu_bits (psdu),
    .i_ndbps     (ndbps),
    .i_in_valid  (in_valid),
    .i_in_bit    (in_bit),
    .o_in_ready  (in_ready),
    .o_enc_rst_n (enc_rst_n),
    .o_enc_en    (enc_en),
    .o_enc_din   (enc_din),
    .i_enc_out   (enc_out),
    .o_out_valid (out_valid),
    .o_out_bits  (out_bits),
    .o_out_mask  (out_mask),
    .o_busy      (busy),
`ifdef CONV_ENC_CTRL_STATS_EN
    .o_coded_bits(coded_bits),
`endif
    .o_done      (done)
  );

  // g0 = 133 (A), g1 = 171 (B); s[0] is the most recent past bit
  function automatic logic [1:0] conv_k7(input logic d, input logic [5:0] s);
    logic a, b;
    a = d ^ s[1] ^ s[2] ^ s[4] ^ s[5];
    b = d ^ s[0] ^ s[1] ^ s[2] ^ s[5];
    return {b, a};
  endfunction

  function automatic logic data_bit(input int k, input int pat);
    if (pat == 1) return 1'b1;
    return (((k * 13) + (k >> 2)) % 7) < 3;
  endfunction

  function automatic logic [1:0] exp_mask(input int rate, input int idx);
    if (rate == 2) return (idx % 3 == 0) ? 2'b11 : ((idx % 3 == 1) ? 2'b01 : 2'b10);
    if (rate == 1) return (idx % 2 == 0) ? 2'b11 : 2'b01;
    return 2'b11;
  endfunction

  function automatic int exp_ones(input int p, input int pat);
    int n;
    n = 0;
    for (int k = 0; k < p; k++) if (data_bit(k, pat)) n++;
    return n;
  endfunction

  always @(posedge clk) begin
    if (!enc_rst_n) begin
      enc_sr  <= 6'd0;
      enc_out <= 2'b00;
    end else if (enc_en) begin
      enc_out <= conv_k7(enc_din, enc_sr);
      enc_sr  <= {enc_sr[4:0], enc_din};
    end
  end

  always @(negedge clk) begin : mon
    logic [1:0] eb;
    logic d;
    if (mon_clr) begin
      en_cnt = 0; din_ones = 0; ov_cnt = 0; kept = 0; rst_lo = 0;
      done_cnt = 0; mask_err = 0; bits_err = 0; first_bits = 2'b00; sw_sr = 6'd0;
    end else begin
      if (!enc_rst_n) rst_lo++;
      if (enc_en) begin
        en_cnt++;
        if (enc_din) din_ones++;
      end
      if (out_valid) begin
        if (out_mask !== exp_mask(cur_rate, ov_cnt)) mask_err++;
        d = (ov_cnt < cur_psdu) ? data_bit(ov_cnt, cur_pat) : 1'b0;
        eb = conv_k7(d, sw_sr);
        sw_sr = {sw_sr[4:0], d};
        if (ov_cnt == 0) first_bits = out_bits;
        if (out_bits !== eb) bits_err++;
        ov_cnt++;
        kept += int'(out_mask[0]) + int'(out_mask[1]);
      end
      if (done) done_cnt++;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic clear_mon();
    mon_clr = 1'b1;
    @(negedge clk);
    #1 mon_clr = 1'b0;
  endtask

  task automatic do_start(input int r, input int p, input int n);
    @(posedge clk);
    #1;
    rate_sel = 2'(r);
    psdu     = 16'(p);
    ndbps    = 9'(n);
    start    = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  function automatic int out_pack();
    return int'({in_ready, enc_en, enc_din, enc_rst_n, out_valid, out_bits, out_mask, busy, done});
  endfunction

  task automatic run_vector(input vec_t v, input string tag);
    int cyc, src;
    logic hs;
    cur_rate = v.rate; cur_psdu = v.psdu; cur_pat = v.pat;
    clear_mon();
    src = 0;
    do_start(v.rate, v.psdu, v.ndbps);
    cyc = 0;
    while (done_cnt == 0 && cyc < 3000) begin
      in_valid = v.gap != 0 ? ($urandom_range(0, 2) != 0) : 1'b1;
      in_bit   = data_bit(src, v.pat);
      start    = (v.bstart != 0 && cyc == 5);
      @(negedge clk);
      if (cyc == 0) check({tag, " busy_after_start"}, int'(busy), 1);
      hs = in_valid && in_ready;
      @(posedge clk);
      #1;
      if (hs) src++;
      cyc++;
    end
    start = 1'b0;
    in_valid = 1'b0;
    if (cyc >= 3000) check({tag, " timeout"}, cyc, 0);
    repeat (4) @(posedge clk);
    #1;
    check({tag, " busy_idle"}, int'(busy), 0);
    check({tag, " enc_en_cnt"}, en_cnt, v.exp_en);
    check({tag, " out_valid_cnt"}, ov_cnt, v.exp_en);
    check({tag, " kept_bits"}, kept, v.exp_kept);
    check({tag, " enc_rst_low"}, rst_lo, 1);
    check({tag, " done_pulses"}, done_cnt, 1);
    check({tag, " mask_errs"}, mask_err, 0);
    check({tag, " out_bits_errs"}, bits_err, 0);
    check({tag, " din_ones"}, din_ones, exp_ones(v.psdu, v.pat));
    check({tag, " handshakes"}, src, v.psdu);
`ifdef CONV_ENC_CTRL_STATS_EN
    check({tag, " coded_bits"}, int'(coded_bits), v.exp_kept);
`endif
  endtask

  initial begin
    vec_t vecs[7];
    vec_t post_rst;
    vecs[0] = '{0, 10, 24, 0, 0, 0, 24, 48};
    vecs[1] = '{2, 30, 36, 0, 0, 0, 36, 48};
    vecs[2] = '{1, 100, 96, 0, 1, 0, 192, 288};
    vecs[3] = '{1, 100, 96, 0, 0, 0, 192, 288};
    vecs[4] = '{0, 0, 24, 0, 0, 0, 24, 48};
    vecs[5] = '{3, 20, 48, 0, 0, 1, 48, 96};
    vecs[6] = '{2, 1, 1, 1, 0, 0, 7, 10};
    post_rst = '{2, 12, 24, 1, 0, 0, 24, 32};

    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", out_pack(), 128);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) run_vector(vecs[i], $sformatf("vec%0d", i));

    // Abort a frame mid-DATA with the async reset, then re-run on a clean encoder.
    cur_rate = 2; cur_psdu = 50; cur_pat = 1;
    clear_mon();
    in_valid = 1'b1;
    in_bit   = 1'b1;
    do_start(2, 50, 48);
    repeat (10) @(posedge clk);
    #1;
    check("midframe_in_ready", int'(in_ready), 1);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("async_reset_outputs", out_pack(), 128);
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("no_done_after_abort", done_cnt, 0);
    run_vector(post_rst, "post_rst");
    check("post_rst first_bits", int'(first_bits), 3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
